// File: rtl/buscaminas_pkg.sv
// Shared types and defaults for the BuscaMinas button command receiver.
package buscaminas_pkg;

  // Command tokens delivered to the game FSM.
  typedef enum logic [1:0] {
    CMD_DOWN    = 2'd0,
    CMD_RIGHT   = 2'd1,
    CMD_BOMBA   = 2'd2,
    CMD_BANDERA = 2'd3
  } cmd_t;

  // Per-button debouncer states.
  typedef enum logic [1:0] {
    DB_HIGH      = 2'd0,
    DB_WAIT_LOW  = 2'd1,
    DB_LOW       = 2'd2,
    DB_WAIT_HIGH = 2'd3
  } db_state_t;

  localparam int unsigned DEF_SYNC_STAGES     = 32'd2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd4;
  localparam int unsigned DEF_FIFO_DEPTH      = 32'd4;
  localparam int unsigned NUM_BUTTONS         = 32'd4;

  // Fixed-priority pick: bit 0 (DOWN) wins over bit 3 (BANDERA).
  function automatic cmd_t prio_pick(input logic [NUM_BUTTONS-1:0] req);
    cmd_t pick;
    pick = CMD_DOWN;
    casez (req)
      4'b???1: pick = CMD_DOWN;
      4'b??10: pick = CMD_RIGHT;
      4'b?100: pick = CMD_BOMBA;
      4'b1000: pick = CMD_BANDERA;
      default: pick = CMD_DOWN;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/boton_comando_rx_if.sv
// Command queue handshake bundle between the button receiver and the game FSM.
interface boton_comando_rx_if
  import buscaminas_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             cmd_valid;
  cmd_t             cmd_code;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_count;
  logic             drop_flag;

  // Producer side: the receiver.
  modport master (
    output cmd_valid,
    output cmd_code,
    output cmd_count,
    output drop_flag,
    input  cmd_ready
  );

  // Consumer side: the game FSM.
  modport slave (
    input  cmd_valid,
    input  cmd_code,
    input  cmd_count,
    input  drop_flag,
    output cmd_ready
  );
endinterface

// File: rtl/boton_comando_rx_debouncer.sv
// Synchroniser plus debounce FSM for one active-low button; emits a
// one-cycle registered pulse on every accepted press (never on release).
module boton_debouncer
  import buscaminas_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic press
);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  db_state_t              state_r;
  db_state_t              state_nxt_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic                   press_r;
  logic                   press_nxt_s;

  assign sync_s = sync_r[SYNC_STAGES-1];
  assign press  = press_r;

  // Plain flop chain; resets to released so a held button reads as a new press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], button};
    end
  end

  // State, counter and press-pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= DB_HIGH;
      cnt_r   <= CNT_ZERO;
      press_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      press_r <= press_nxt_s;
    end
  end

  // Next state: a level change must persist DEBOUNCE_CYCLES synchronised cycles.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      DB_HIGH: begin
        if (!sync_s) begin
          if (DEBOUNCE_CYCLES == 32'd1) begin
            state_nxt_s = DB_LOW;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            state_nxt_s = DB_WAIT_LOW;
            cnt_nxt_s   = CNT_ONE;
          end
        end else begin
          state_nxt_s = DB_HIGH;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      DB_WAIT_LOW: begin
        if (!sync_s) begin
          if (cnt_r >= CNT_LAST) begin
            state_nxt_s = DB_LOW;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            state_nxt_s = DB_WAIT_LOW;
            cnt_nxt_s   = cnt_r + CNT_ONE;
          end
        end else begin
          state_nxt_s = DB_HIGH;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      DB_LOW: begin
        if (sync_s) begin
          if (DEBOUNCE_CYCLES == 32'd1) begin
            state_nxt_s = DB_HIGH;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            state_nxt_s = DB_WAIT_HIGH;
            cnt_nxt_s   = CNT_ONE;
          end
        end else begin
          state_nxt_s = DB_LOW;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      DB_WAIT_HIGH: begin
        if (sync_s) begin
          if (cnt_r >= CNT_LAST) begin
            state_nxt_s = DB_HIGH;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            state_nxt_s = DB_WAIT_HIGH;
            cnt_nxt_s   = cnt_r + CNT_ONE;
          end
        end else begin
          state_nxt_s = DB_LOW;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      default: begin
        state_nxt_s = DB_HIGH;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Press pulse: only the released-to-pressed transition produces a token.
  always_comb begin
    press_nxt_s = 1'b0;
    if ((state_r == DB_HIGH || state_r == DB_WAIT_LOW) && state_nxt_s == DB_LOW) begin
      press_nxt_s = 1'b1;
    end else begin
      press_nxt_s = 1'b0;
    end
  end

endmodule

// File: rtl/boton_comando_rx.sv
// Button receiver top: four debouncers, pending flags, fixed-priority
// arbiter and a first-word-fall-through command FIFO.
module boton_comando_rx
  import buscaminas_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      button_down,
  input  logic                      button_right,
  input  logic                      button_bomba,
  input  logic                      button_bandera,
  boton_comando_rx_if.master        cmd_if
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [NUM_BUTTONS-1:0] raw_s;
  logic [NUM_BUTTONS-1:0] press_s;
  logic [NUM_BUTTONS-1:0] pending_r;
  logic [NUM_BUTTONS-1:0] clear_s;
  logic                   drop_r;
  cmd_t                   pick_s;
  logic                   full_s;
  logic                   pop_s;
  logic                   push_s;
  cmd_t                   mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [CNT_W-1:0]       count_r;
  logic [CNT_W-1:0]       count_nxt_s;
  logic                   valid_r;

  // Bit order matches cmd_t encoding so the arbiter index is the code.
  assign raw_s = {button_bandera, button_bomba, button_right, button_down};

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
    boton_debouncer #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .button (raw_s[g]),
      .press  (press_s[g])
    );
  end

  // Arbiter: push the highest-priority pending code when the queue can take it.
  always_comb begin
    full_s = (count_r == CNT_W'(FIFO_DEPTH));
    pop_s  = valid_r && cmd_if.cmd_ready;
    pick_s = prio_pick(pending_r);
    if ((pending_r != {NUM_BUTTONS{1'b0}}) && (!full_s || pop_s)) begin
      push_s  = 1'b1;
      clear_s = 4'b0001 << pick_s;
    end else begin
      push_s  = 1'b0;
      clear_s = 4'b0000;
    end
  end

  // Occupancy update; simultaneous push and pop leave it unchanged.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pending flags and sticky drop: a second press before the first is queued is lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_r <= {NUM_BUTTONS{1'b0}};
      drop_r    <= 1'b0;
    end else begin
      pending_r <= (pending_r & ~clear_s) | press_s;
      drop_r    <= drop_r | (|(press_s & pending_r & ~clear_s));
    end
  end

  // FIFO storage and pointers; pointers wrap naturally at a power-of-2 depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= CMD_DOWN;
      end
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
      valid_r  <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= pick_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != CNT_W'(0));
    end
  end

  assign cmd_if.cmd_valid = valid_r;
  assign cmd_if.cmd_code  = mem_r[rd_ptr_r];
  assign cmd_if.cmd_count = count_r;
  assign cmd_if.drop_flag = drop_r;

endmodule

// File: tb/tb_boton_comando_rx.sv
// Directed self-checking bench for boton_comando_rx with default parameters.
module tb_boton_comando_rx;
  import buscaminas_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic button_down = 1'b1;
  logic button_right = 1'b1;
  logic button_bomba = 1'b1;
  logic button_bandera = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  boton_comando_rx_if #(.FIFO_DEPTH(4)) cmd_if ();

  boton_comando_rx dut (
    .clk            (clk),
    .rst            (rst),
    .button_down    (button_down),
    .button_right   (button_right),
    .button_bomba   (button_bomba),
    .button_bandera (button_bandera),
    .cmd_if         (cmd_if)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_all(input logic v);
    button_down = v; button_right = v; button_bomba = v; button_bandera = v;
  endtask

  task automatic test_reset();
    rst = 1'b0; set_all(1'b1); cmd_if.cmd_ready = 1'b0;
    tick(3);
    n_vec++; if (cmd_if.cmd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", cmd_if.cmd_valid); end
    n_vec++; if (cmd_if.cmd_count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", cmd_if.cmd_count); end
    n_vec++; if (cmd_if.drop_flag !== 1'b0) begin n_err++; $display("FAIL reset_drop got %0b want 0", cmd_if.drop_flag); end
    n_vec++; if (cmd_if.cmd_code !== CMD_DOWN) begin n_err++; $display("FAIL reset_code got %0d want 0", cmd_if.cmd_code); end
    rst = 1'b1;
    tick(20);
    n_vec++; if (cmd_if.cmd_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid got %0b want 0", cmd_if.cmd_valid); end
    n_vec++; if (cmd_if.cmd_count !== 3'd0) begin n_err++; $display("FAIL idle_count got %0d want 0", cmd_if.cmd_count); end
  endtask

  task automatic test_glitch();
    cmd_if.cmd_ready = 1'b0;
    button_down = 1'b0;
    tick(3);
    button_down = 1'b1;
    tick(15);
    n_vec++; if (cmd_if.cmd_count !== 3'd0) begin n_err++; $display("FAIL glitch_count got %0d want 0", cmd_if.cmd_count); end
    n_vec++; if (cmd_if.cmd_valid !== 1'b0) begin n_err++; $display("FAIL glitch_valid got %0b want 0", cmd_if.cmd_valid); end
  endtask

  // Low sampled from edge k; valid must rise only after edge k+7 and last one cycle.
  task automatic test_single_press();
    cmd_if.cmd_ready = 1'b1;
    button_right = 1'b0;
    for (int j = 1; j <= 25; j++) begin
      @(negedge clk);
      n_vec++;
      if (cmd_if.cmd_valid !== (j == 8)) begin
        n_err++; $display("FAIL single_valid cycle %0d got %0b want %0b", j, cmd_if.cmd_valid, (j == 8));
      end
      if (j == 8) begin
        n_vec++;
        if (cmd_if.cmd_code !== CMD_RIGHT) begin n_err++; $display("FAIL single_code got %0d want 1", cmd_if.cmd_code); end
      end
      if (j == 10) button_right = 1'b1;
    end
    cmd_if.cmd_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    cmd_t exp_order [4] = '{CMD_DOWN, CMD_RIGHT, CMD_BOMBA, CMD_BANDERA};
    cmd_if.cmd_ready = 1'b0;
    set_all(1'b0);
    tick(15);
    n_vec++; if (cmd_if.cmd_count !== 3'd4) begin n_err++; $display("FAIL simul_count got %0d want 4", cmd_if.cmd_count); end
    cmd_if.cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (cmd_if.cmd_valid !== 1'b1 || cmd_if.cmd_code !== exp_order[i]) begin
        n_err++; $display("FAIL simul_pop%0d got valid %0b code %0d want valid 1 code %0d", i, cmd_if.cmd_valid, cmd_if.cmd_code, exp_order[i]);
      end
      @(negedge clk);
    end
    n_vec++; if (cmd_if.cmd_valid !== 1'b0) begin n_err++; $display("FAIL simul_empty got %0b want 0", cmd_if.cmd_valid); end
    n_vec++; if (cmd_if.drop_flag !== 1'b0) begin n_err++; $display("FAIL simul_drop got %0b want 0", cmd_if.drop_flag); end
    cmd_if.cmd_ready = 1'b0;
    set_all(1'b1);
    tick(15);
  endtask

  task automatic test_full_drop();
    cmd_t exp_order [5] = '{CMD_DOWN, CMD_RIGHT, CMD_BOMBA, CMD_BANDERA, CMD_BOMBA};
    cmd_if.cmd_ready = 1'b0;
    set_all(1'b0); tick(12); set_all(1'b1); tick(12);
    n_vec++; if (cmd_if.cmd_count !== 3'd4) begin n_err++; $display("FAIL full_count got %0d want 4", cmd_if.cmd_count); end
    button_bomba = 1'b0; tick(8); button_bomba = 1'b1; tick(12);
    n_vec++; if (cmd_if.cmd_count !== 3'd4) begin n_err++; $display("FAIL full_hold_count got %0d want 4", cmd_if.cmd_count); end
    n_vec++; if (cmd_if.drop_flag !== 1'b0) begin n_err++; $display("FAIL full_nodrop got %0b want 0", cmd_if.drop_flag); end
    button_bomba = 1'b0; tick(8); button_bomba = 1'b1; tick(12);
    n_vec++; if (cmd_if.drop_flag !== 1'b1) begin n_err++; $display("FAIL full_drop got %0b want 1", cmd_if.drop_flag); end
    cmd_if.cmd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (cmd_if.cmd_valid !== 1'b1 || cmd_if.cmd_code !== exp_order[i]) begin
        n_err++; $display("FAIL full_pop%0d got valid %0b code %0d want valid 1 code %0d", i, cmd_if.cmd_valid, cmd_if.cmd_code, exp_order[i]);
      end
      @(negedge clk);
    end
    n_vec++; if (cmd_if.cmd_valid !== 1'b0) begin n_err++; $display("FAIL full_empty got %0b want 0", cmd_if.cmd_valid); end
    n_vec++; if (cmd_if.drop_flag !== 1'b1) begin n_err++; $display("FAIL full_drop_sticky got %0b want 1", cmd_if.drop_flag); end
    cmd_if.cmd_ready = 1'b0;
  endtask

  task automatic test_reset_mid_hold();
    cmd_if.cmd_ready = 1'b0;
    button_down = 1'b0; button_right = 1'b0; tick(12);
    button_down = 1'b1; button_right = 1'b1; tick(12);
    n_vec++; if (cmd_if.cmd_count !== 3'd2) begin n_err++; $display("FAIL mid_pre_count got %0d want 2", cmd_if.cmd_count); end
    button_bandera = 1'b0; tick(12);
    rst = 1'b0;
    #1;
    n_vec++; if (cmd_if.cmd_count !== 3'd0) begin n_err++; $display("FAIL mid_rst_count got %0d want 0", cmd_if.cmd_count); end
    n_vec++; if (cmd_if.drop_flag !== 1'b0) begin n_err++; $display("FAIL mid_rst_drop got %0b want 0", cmd_if.drop_flag); end
    @(negedge clk);
    rst = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      n_vec++;
      if (cmd_if.cmd_valid !== (j >= 8)) begin
        n_err++; $display("FAIL mid_valid cycle %0d got %0b want %0b", j, cmd_if.cmd_valid, (j >= 8));
      end
      if (j == 8) begin
        n_vec++;
        if (cmd_if.cmd_code !== CMD_BANDERA) begin n_err++; $display("FAIL mid_code got %0d want 3", cmd_if.cmd_code); end
      end
    end
    button_bandera = 1'b1; tick(15);
    n_vec++; if (cmd_if.cmd_count !== 3'd1) begin n_err++; $display("FAIL mid_once_count got %0d want 1", cmd_if.cmd_count); end
    cmd_if.cmd_ready = 1'b1; tick(1);
    n_vec++; if (cmd_if.cmd_valid !== 1'b0) begin n_err++; $display("FAIL mid_drain got %0b want 0", cmd_if.cmd_valid); end
    cmd_if.cmd_ready = 1'b0;
  endtask

  initial begin
    cmd_if.cmd_ready = 1'b0;
    test_reset();
    test_glitch();
    test_single_press();
    test_simultaneous();
    test_full_drop();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/boton_comando_rx.md
Name: boton_comando_rx

Overview:
- Receive end of the BuscaMinas player-button interface.
- Takes the four raw active-low push-buttons (down, right, bomba, bandera), idle 1, pressed 0.
- Synchronises and debounces each button and turns every press into exactly one command token.
- Queues the tokens in a small first-word-fall-through FIFO, drained by the game FSM through a valid/ready handshake.

Parameters:
- SYNC_STAGES, 2, synchroniser flip-flops per button (legal values 2 or 3).
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles required to accept a level change (1..65535).
- FIFO_DEPTH, 4, command queue entries (power of 2, at least 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- button_down  in  1  raw button, active-low.
- button_right  in  1  raw button, active-low.
- button_bomba  in  1  raw button, active-low.
- button_bandera  in  1  raw button, active-low.
- cmd_valid  out  1  queue head holds a command.
- cmd_code  out  2  head command, type cmd_t.
- cmd_ready  in  1  consumer accepts the head this cycle.
- cmd_count  out  $clog2(FIFO_DEPTH)+1  number of queued entries.
- drop_flag  out  1  sticky: at least one press was lost; cleared only by rst.

Behaviour:
- Reset (rst=0, asynchronous):
  - Synchroniser flops and debounced states go to 1 (released).
  - Debounce counters, pending flags, FIFO pointers and cmd_count go to 0.
  - cmd_valid=0, cmd_code=CMD_DOWN, drop_flag=0.
- Synchroniser: SYNC_STAGES flip-flop chain per button, no logic between stages.
- Debouncer FSM, one per button. States: HIGH, WAIT_LOW, LOW, WAIT_HIGH.
  - HIGH: synchronised value 0 -> WAIT_LOW, counter=1.
  - WAIT_LOW: synchronised 0 -> counter+1. Counter reaching DEBOUNCE_CYCLES -> LOW and a one-cycle press pulse. Synchronised 1 -> HIGH, counter=0.
  - LOW and WAIT_HIGH are symmetric, with no pulse. Releases never generate commands.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1) and never wraps.
- Pending flags, one per button:
  - A press pulse sets the flag.
  - A press pulse while the flag is already set leaves it set and sets drop_flag.
- Arbiter: each cycle picks the highest-priority set pending flag, order DOWN > RIGHT > BOMBA > BANDERA. It pushes that code and clears that flag when push is allowed. At most one push per cycle.
- Push is allowed when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - When the FIFO is full and no pop occurs, the pending flags hold. Nothing is lost until a second press of the same button arrives.
- FIFO:
  - First-word fall-through: cmd_valid = (cmd_count != 0), cmd_code = head entry.
  - A pop happens when cmd_valid && cmd_ready. cmd_ready while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - cmd_count is registered: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Latency: raw input first sampled low at edge k, held low, FIFO empty, no competing pending flags -> cmd_valid high after edge k+SYNC_STAGES+DEBOUNCE_CYCLES+1. With defaults that is edge k+7.
- Pulses shorter than DEBOUNCE_CYCLES synchronised cycles produce no command.
- A button held low through reset deassertion produces one command after debounce, because the debounced state resets to released.
- Reset mid-operation discards queued and pending commands immediately.

Decomposition:
- buscaminas_pkg holds:
  - typedef enum logic [1:0] cmd_t {CMD_DOWN=0, CMD_RIGHT=1, CMD_BOMBA=2, CMD_BANDERA=3}.
  - The debouncer state enum.
  - Default-parameter localparams.
- Sub-module boton_debouncer (synchroniser, FSM and counter, press-pulse output), instanced four times.
- Pending flags, arbiter and FIFO live in boton_comando_rx.

Test Plan:
- Reset: rst=0 with all buttons 1 -> cmd_valid=0, cmd_count=0, drop_flag=0. Release reset and idle 20 cycles -> still empty.
- Glitch: button_down=0 for 3 cycles, then 1, cmd_ready=0 -> no command, cmd_count stays 0.
- Single press: button_right=0 for 10 cycles from edge k, cmd_ready=1 -> cmd_valid high for exactly one cycle after edge k+7 with cmd_code=CMD_RIGHT; release -> no further command.
- Simultaneous press: all four buttons low in the same cycle, cmd_ready=0 -> cmd_count reaches 4. Queue order DOWN, RIGHT, BOMBA, BANDERA. Then cmd_ready=1 -> four consecutive pops in that order, after which cmd_valid=0.
- Full and drop: queue full (4 entries), press bomba -> pending holds and cmd_count stays 4. Press bomba again -> drop_flag=1. Then cmd_ready=1 -> five commands out, the last one CMD_BOMBA. drop_flag stays 1.
- Reset mid-hold: button_bandera held low with 2 entries queued, rst pulsed -> cmd_count=0 immediately. After release, exactly one CMD_BANDERA appears at DEBOUNCE_CYCLES+SYNC_STAGES+1 cycles.
